mig_truth_table_engine: RTL

Programmable majority-inverter-graph (MIG) evaluator for the N-input Boolean function classification flow. A host loads a small netlist of 3-input majority gates with optional operand complementation. On start, the block sweeps all 2^N_IN input vectors, one per cycle, and assembles the complete truth table into a register for readout. It replaces per-function hard-wired majority netlists with one reusable, reconfigurable block.

---
 rtl/mig_truth_table_engine.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/mig_truth_table_engine.sv
// Programmable majority-inverter-graph evaluator: a small netlist of complemented
// 3-input majority gates is swept over all 2^N_IN input vectors to build a truth table.
module mig_truth_table_engine #(
    parameter int  N_IN    = 7,
    parameter int  N_GATES = 8,
    localparam int SEL_W   = $clog2(1 + N_IN + N_GATES),
    localparam int GI_W    = (N_GATES > 1) ? $clog2(N_GATES) : 1,
    localparam int TT_W    = 2 ** N_IN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [GI_W-1:0]    cfg_gate,
    input  logic [SEL_W-1:0]   cfg_sel_a,
    input  logic [SEL_W-1:0]   cfg_sel_b,
    input  logic [SEL_W-1:0]   cfg_sel_c,
    input  logic               cfg_inv_a,
    input  logic               cfg_inv_b,
    input  logic               cfg_inv_c,
    input  logic [GI_W-1:0]    out_gate,
    input  logic               out_inv,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [TT_W-1:0]    tt,
    output logic               tt_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [N_GATES-1:0][2:0][SEL_W-1:0] sel_arr_t;
    typedef logic [N_GATES-1:0][2:0]            inv_arr_t;

    function automatic logic maj3(input logic [2:0] op);
        return (op[0] & op[1]) | (op[0] & op[2]) | (op[1] & op[2]);
    endfunction

    // Gate k may only see constants, primary inputs and strictly earlier gates.
    function automatic logic sel_legal(input logic [SEL_W-1:0] sel, input int k);
        int s;
        s = int'(sel);
        if (s <= N_IN) begin
            return 1'b1;
        end else begin
            return (s - (N_IN + 1)) < k;
        end
    endfunction

    function automatic logic gate_in_range(input int g);
        return g < N_GATES;
    endfunction

    function automatic logic operand_val(input logic [SEL_W-1:0] sel,
                                         input logic [N_IN-1:0] x,
                                         input logic [N_GATES-1:0] g);
        int   s;
        logic r;
        s = int'(sel);
        r = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            r = (s == i + 1) ? x[i] : r;
        end
        for (int j = 0; j < N_GATES; j++) begin
            r = (s == N_IN + 1 + j) ? g[j] : r;
        end
        return r;
    endfunction

    // Gates are evaluated in slot order so each one sees its (earlier) fan-in already settled.
    function automatic logic eval_netlist(input logic [N_IN-1:0] x,
                                          input sel_arr_t sel,
                                          input inv_arr_t inv,
                                          input logic [GI_W-1:0] og,
                                          input logic oi,
                                          input logic og_ok);
        logic [N_GATES-1:0] g;
        logic [2:0]         op;
        logic               r;
        g = '0;
        for (int k = 0; k < N_GATES; k++) begin
            for (int o = 0; o < 3; o++) begin
                op[o] = operand_val(sel[k][o], x, g) ^ inv[k][o];
            end
            g[k] = maj3(op);
        end
        r = 1'b0;
        for (int k = 0; k < N_GATES; k++) begin
            r = (int'(og) == k) ? g[k] : r;
        end
        return og_ok ? (r ^ oi) : 1'b0;
    endfunction

    state_t                 state_r;
    logic [N_IN-1:0]        v_r;
    logic [TT_W-1:0]        tt_r;
    logic                   tt_valid_r;
    logic                   done_r;
    logic                   busy_r;
    logic                   cfg_err_r;
    logic [GI_W-1:0]        og_r;
    logic                   oi_r;
    logic                   og_ok_r;
    sel_arr_t               sel_r;
    inv_arr_t               inv_r;

    logic                   cfg_ready_s;
    logic                   cfg_wr_s;
    logic                   start_acc_s;
    logic                   gate_ok_s;
    logic                   og_ok_s;
    logic [2:0][SEL_W-1:0]  in_sel_s;
    logic [2:0]             in_inv_s;
    logic [2:0][SEL_W-1:0]  wr_sel_s;
    logic [2:0]             wr_inv_s;
    logic                   wr_bad_s;
    logic                   eval_s;

    assign cfg_ready_s = (state_r == IDLE) && !start;
    assign cfg_wr_s    = cfg_valid && cfg_ready_s;
    assign start_acc_s = (state_r == IDLE) && start;
    assign gate_ok_s   = gate_in_range(int'(cfg_gate));
    assign og_ok_s     = gate_in_range(int'(out_gate));
    assign in_sel_s    = {cfg_sel_c, cfg_sel_b, cfg_sel_a};
    assign in_inv_s    = {cfg_inv_c, cfg_inv_b, cfg_inv_a};

    // Sanitise incoming operands: illegal selects become non-inverted constant 0.
    always_comb begin
        wr_sel_s = '0;
        wr_inv_s = '0;
        wr_bad_s = 1'b0;
        for (int o = 0; o < 3; o++) begin
            if (sel_legal(in_sel_s[o], int'(cfg_gate))) begin
                wr_sel_s[o] = in_sel_s[o];
                wr_inv_s[o] = in_inv_s[o];
            end else begin
                wr_bad_s = 1'b1;
            end
        end
    end

    // Netlist result for the vector currently addressed by the sweep counter.
    always_comb begin
        eval_s = eval_netlist(v_r, sel_r, inv_r, og_r, oi_r, og_ok_r);
    end

    // Gate configuration storage and the sticky configuration error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r     <= '0;
            inv_r     <= '0;
            cfg_err_r <= 1'b0;
        end else if (cfg_wr_s) begin
            if (gate_ok_s) begin
                sel_r[cfg_gate] <= wr_sel_s;
                inv_r[cfg_gate] <= wr_inv_s;
                cfg_err_r       <= cfg_err_r | wr_bad_s;
            end else begin
                cfg_err_r <= 1'b1;
            end
        end else if (start_acc_s && !og_ok_s) begin
            cfg_err_r <= 1'b1;
        end else begin
            cfg_err_r <= cfg_err_r;
        end
    end

    // Sweep controller: one vector per RUN cycle, single-cycle DONE, then back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            v_r        <= '0;
            tt_r       <= '0;
            tt_valid_r <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            og_r       <= '0;
            oi_r       <= 1'b0;
            og_ok_r    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r    <= RUN;
                        v_r        <= '0;
                        og_r       <= out_gate;
                        oi_r       <= out_inv;
                        og_ok_r    <= og_ok_s;
                        tt_r       <= '0;
                        tt_valid_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    tt_r[v_r] <= eval_s;
                    if (v_r == '1) begin
                        state_r    <= DONE;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        tt_valid_r <= 1'b1;
                    end else begin
                        v_r <= v_r + 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = cfg_ready_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_err   = cfg_err_r;
    assign tt        = tt_r;
    assign tt_valid  = tt_valid_r;

endmodule
